// File: rtl/tap_arbiter.sv
// Epoch-based tap collector: a rising ping edge opens an epoch, enabled taps are
// granted round-robin into a single registered output until all report or the epoch times out.
module tap_arbiter #(
  parameter int N_TAPS      = 4,
  parameter int DATA_WIDTH  = 40,
  parameter int EPOCH_WIDTH = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ping,
  input  logic [N_TAPS-1:0]            tap_enable,
  input  logic [N_TAPS-1:0]            tap_valid,
  input  logic [N_TAPS*DATA_WIDTH-1:0] tap_data,
  output logic [N_TAPS-1:0]            tap_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(N_TAPS)-1:0]    out_tap_id,
  output logic [EPOCH_WIDTH-1:0]       out_epoch,
  output logic                         epoch_done,
  output logic                         busy,
  output logic [N_TAPS-1:0]            missed_mask,
  output logic                         ping_overrun
);

  localparam int ID_W = $clog2(N_TAPS);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                  state_q, state_d;
  logic [N_TAPS-1:0]       pending_q, pending_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [ID_W-1:0]         start_ptr_q, start_ptr_d;
  logic [EPOCH_WIDTH-1:0]  epoch_q, epoch_d;
  logic                    ping_q, armed_q, armed_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic [EPOCH_WIDTH-1:0]  out_epoch_q, out_epoch_d;
  logic                    epoch_done_q, epoch_done_d;
  logic [N_TAPS-1:0]       missed_q, missed_d;
  logic                    overrun_q, overrun_d;

  logic                    ping_edge;
  logic [N_TAPS-1:0]       req;
  logic                    grant_found;
  logic [ID_W-1:0]         grant_idx;
  logic [N_TAPS-1:0]       grant_oh;
  logic [DATA_WIDTH-1:0]   grant_word;
  logic                    out_free;
  logic                    xfer;
  logic [ID_W:0]           idx_ext;

  // armed_q keeps a ping held high across reset from looking like a fresh edge
  assign ping_edge = ping & ~ping_q & armed_q;
  assign armed_d   = armed_q | ~ping;

  assign req      = (state_q == COLLECT) ? (pending_q & tap_valid) : '0;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    grant_word  = '0;
    idx_ext     = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      idx_ext = {1'b0, start_ptr_q} + (ID_W+1)'(k);
      if (idx_ext >= (ID_W+1)'(N_TAPS)) idx_ext = idx_ext - (ID_W+1)'(N_TAPS);
      if (!grant_found && req[idx_ext[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_ext[ID_W-1:0];
      end
    end
    if (grant_found) grant_oh[grant_idx] = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      if (grant_oh[i]) grant_word = tap_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign tap_ready = out_free ? grant_oh : '0;
  assign xfer      = |(tap_ready & tap_valid);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    timer_d      = timer_q;
    start_ptr_d  = start_ptr_q;
    epoch_d      = epoch_q;
    epoch_done_d = 1'b0;
    missed_d     = missed_q;
    overrun_d    = overrun_q | (ping_edge && (state_q == COLLECT));
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    out_epoch_d  = out_epoch_q;

    case (state_q)
      IDLE: begin
        if (ping_edge) begin
          state_d   = COLLECT;
          pending_d = tap_enable;
          epoch_d   = epoch_q + EPOCH_WIDTH'(1);
          timer_d   = '0;
        end
      end
      COLLECT: begin
        if (xfer) pending_d = pending_q & ~grant_oh;
        timer_d = timer_q + TW'(1);
        if ((pending_d == '0) || (timer_q == TW'(TIMEOUT - 1))) begin
          state_d      = IDLE;
          epoch_done_d = 1'b1;
          missed_d     = pending_d;
          start_ptr_d  = (start_ptr_q == ID_W'(N_TAPS - 1)) ? '0 : start_ptr_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The output register runs its own handshake, independent of the epoch FSM
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_word;
      out_id_d    = grant_idx;
      out_epoch_d = epoch_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      timer_q      <= '0;
      start_ptr_q  <= '0;
      epoch_q      <= '0;
      ping_q       <= 1'b0;
      armed_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      out_epoch_q  <= '0;
      epoch_done_q <= 1'b0;
      missed_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      timer_q      <= timer_d;
      start_ptr_q  <= start_ptr_d;
      epoch_q      <= epoch_d;
      ping_q       <= ping;
      armed_q      <= armed_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      out_epoch_q  <= out_epoch_d;
      epoch_done_q <= epoch_done_d;
      missed_q     <= missed_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_tap_id   = out_id_q;
  assign out_epoch    = out_epoch_q;
  assign epoch_done   = epoch_done_q;
  assign busy         = (state_q == COLLECT);
  assign missed_mask  = missed_q;
  assign ping_overrun = overrun_q;

endmodule

// File: tb/tb_tap_arbiter.sv
// Directed-vector bench for tap_arbiter: rotation, timeout, back-pressure,
// ping overrun and mid-epoch reset, with hand-derived expected values.
module tb_tap_arbiter;

  localparam int N  = 4;
  localparam int DW = 40;
  localparam int EW = 8;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            ping;
  logic [N-1:0]    tap_enable;
  logic [N-1:0]    tap_valid;
  logic [N*DW-1:0] tap_data;
  logic [N-1:0]    tap_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_tap_id;
  logic [EW-1:0]   out_epoch;
  logic            epoch_done;
  logic            busy;
  logic [N-1:0]    missed_mask;
  logic            ping_overrun;

  always #5 clk = ~clk;

  tap_arbiter #(.N_TAPS(N), .DATA_WIDTH(DW), .EPOCH_WIDTH(EW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ping         (ping),
    .tap_enable   (tap_enable),
    .tap_valid    (tap_valid),
    .tap_data     (tap_data),
    .tap_ready    (tap_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tap_id   (out_tap_id),
    .out_epoch    (out_epoch),
    .epoch_done   (epoch_done),
    .busy         (busy),
    .missed_mask  (missed_mask),
    .ping_overrun (ping_overrun)
  );

  typedef struct packed {
    logic [1:0]    id;
    logic [EW-1:0] ep;
    logic [DW-1:0] data;
  } word_t;

  int    n_vec = 0;
  int    n_err = 0;
  word_t got_q[$];
  int    done_cnt = 0;

  function automatic logic [DW-1:0] word(input int i);
    return {8'hA0 + 8'(i), 32'h5EED_0000 + 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Accepted words and epoch_done pulses, sampled on the active edge
  always @(posedge clk) begin
    word_t w;
    if (!rst) begin
      if (out_valid && out_ready) begin
        w = {out_tap_id, out_epoch, out_data};
        got_q.push_back(w);
      end
      if (epoch_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_epoch();
    ping = 1'b1;
    tick();
    ping = 1'b0;
  endtask

  task automatic wait_close(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic check_words(input string tag, input logic [15:0] ids, input int cnt,
                             input logic [EW-1:0] ep);
    check({tag, " count"}, 64'(got_q.size()), 64'(cnt));
    for (int k = 0; k < cnt; k++) begin
      if (k < got_q.size()) begin
        check({tag, " id"},    64'(got_q[k].id),   64'(ids[4*k +: 4]));
        check({tag, " epoch"}, 64'(got_q[k].ep),   64'(ep));
        check({tag, " data"},  64'(got_q[k].data), 64'(word(int'(ids[4*k +: 4]))));
      end
    end
    got_q.delete();
  endtask

  // All taps enabled and valid, out_ready high: one word per cycle from start s
  task automatic run_full(input int s, input logic [EW-1:0] ep);
    start_epoch();
    check("full busy", 64'(busy), 64'd1);
    check("full first grant", 64'(tap_ready), 64'(4'b0001 << s));
    for (int k = 0; k < N; k++) begin
      tick();
      check("full out_valid", 64'(out_valid), 64'd1);
      check("full id", 64'(out_tap_id), 64'((s + k) % N));
      check("full epoch", 64'(out_epoch), 64'(ep));
      check("full data", 64'(out_data), 64'(word((s + k) % N)));
    end
    check("full epoch_done", 64'(epoch_done), 64'd1);
    check("full missed", 64'(missed_mask), 64'd0);
    check("full busy after", 64'(busy), 64'd0);
    tick();
    check("full done pulse", 64'(epoch_done), 64'd0);
    check("full drain", 64'(out_valid), 64'd0);
    got_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; ping = 1'b1; out_ready = 1'b1;
    tap_enable = '1; tap_valid = '1;
    for (int i = 0; i < N; i++) tap_data[i*DW +: DW] = word(i);

    #12;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_epoch", 64'(out_epoch), 64'd0);
    check("rst tap_ready", 64'(tap_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst epoch_done", 64'(epoch_done), 64'd0);
    check("rst missed", 64'(missed_mask), 64'd0);
    check("rst overrun", 64'(ping_overrun), 64'd0);

    // Ping held high through reset release is not an edge
    tick(); rst = 1'b0;
    tick(); tick(); tick();
    check("held ping no edge", 64'(busy), 64'd0);
    ping = 1'b0;
    tick(); tick();

    run_full(0, 8'd1);
    tick();
    run_full(1, 8'd2);

    // Timeout: tap 2 never valid, start_ptr 2
    tap_valid = 4'b1011;
    tick();
    start_epoch();
    wait_close(n);
    check("timeout collect cycles", 64'(n), 64'd10);
    check("timeout epoch_done", 64'(epoch_done), 64'd1);
    check("timeout missed", 64'(missed_mask), 64'b0100);
    tick();
    check_words("timeout", 16'h0103, 3, 8'd3);
    tap_valid = '1;

    // Empty enable still opens and closes an epoch
    tap_enable = '0;
    tick();
    start_epoch();
    check("empty busy", 64'(busy), 64'd1);
    check("missed held", 64'(missed_mask), 64'b0100);
    tick();
    check("empty closed", 64'(busy), 64'd0);
    check("empty epoch_done", 64'(epoch_done), 64'd1);
    check("empty missed", 64'(missed_mask), 64'd0);
    tap_enable = '1;
    tick();
    check("empty no words", 64'(got_q.size()), 64'd0);

    // Back-pressure: out_ready low for 5 cycles after the first word
    start_epoch();
    tick();
    check("stall first id", 64'(out_tap_id), 64'd0);
    out_ready = 1'b0;
    repeat (5) begin
      #1;
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall data", 64'(out_data), 64'(word(0)));
      check("stall tap_ready", 64'(tap_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 1; k < N; k++) begin
      tick();
      check("resume id", 64'(out_tap_id), 64'(k));
    end
    check("stall epoch_done", 64'(epoch_done), 64'd1);
    tick();
    check_words("stall", 16'h3210, 4, 8'd5);

    // Ping edge three cycles into COLLECT
    tick();
    start_epoch();
    tick(); tick();
    ping = 1'b1;
    tick();
    ping = 1'b0;
    check("overrun set", 64'(ping_overrun), 64'd1);
    wait_close(n);
    check("overrun epoch_done", 64'(epoch_done), 64'd1);
    tick();
    check_words("overrun", 16'h0321, 4, 8'd6);

    // Ping edge in the closing cycle does not restart collection
    tick();
    start_epoch();
    tick(); tick(); tick();
    ping = 1'b1;
    tick();
    ping = 1'b0;
    check("close-edge closed", 64'(busy), 64'd0);
    check("close-edge done", 64'(epoch_done), 64'd1);
    tick();
    check("close-edge no reentry", 64'(busy), 64'd0);
    tick();
    check_words("close-edge", 16'h1032, 4, 8'd7);

    // Reset mid-epoch with a held output word
    start_epoch();
    tick();
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    check("pre-reset epoch", 64'(out_epoch), 64'd8);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst out_data", 64'(out_data), 64'd0);
    check("mid rst out_id", 64'(out_tap_id), 64'd0);
    check("mid rst out_epoch", 64'(out_epoch), 64'd0);
    check("mid rst tap_ready", 64'(tap_ready), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst overrun", 64'(ping_overrun), 64'd0);
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    check("abandoned no done", 64'(done_cnt), 64'd7);
    got_q.delete();
    run_full(0, 8'd1);
    check("final done count", 64'(done_cnt), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tap_arbiter.md
TAP_ARBITER -- requirements
Module: tap_arbiter

Interface
REQ-001 Parameter N_TAPS, default 4, number of tap requesters (2..16).
REQ-002 Parameter DATA_WIDTH, default 40, width of one timestamped tap word.
REQ-003 Parameter EPOCH_WIDTH, default 8, width of the epoch counter.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles per epoch spent waiting for pending taps (must be at least 1).
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ping  in  1  global ping level, already synchronous to clk.
REQ-008 tap_enable  in  N_TAPS  per-tap enable, sampled at the start of each epoch.
REQ-009 tap_valid  in  N_TAPS  per-tap word available.
REQ-010 tap_data  in  N_TAPS*DATA_WIDTH  packed tap words; tap i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 tap_ready  out  N_TAPS  one-hot grant; a word transfers when tap_valid[i] and tap_ready[i] are both high.
REQ-012 out_valid, out_ready  out, in  1, 1  output handshake.
REQ-013 out_data  out  DATA_WIDTH  granted tap word.
REQ-014 out_tap_id  out  clog2(N_TAPS)  index of the source tap.
REQ-015 out_epoch  out  EPOCH_WIDTH  epoch number of the word.
REQ-016 epoch_done  out  1  one-cycle pulse when an epoch closes.
REQ-017 busy  out  1  high while in state COLLECT.
REQ-018 missed_mask  out  N_TAPS  taps not collected in the last closed epoch; held until the next epoch_done.
REQ-019 ping_overrun  out  1  sticky flag: a ping edge arrived while busy.

Function
REQ-020 Ping edge = ping high and registered ping low; only rising edges count.
REQ-021 FSM has two states, IDLE and COLLECT; IDLE moves to COLLECT on a ping edge.
- On that transition: pending <= tap_enable; epoch <= epoch+1 (modulo 2^EPOCH_WIDTH); timer <= 0.
REQ-022 An edge with tap_enable all zero still enters COLLECT; the next cycle closes the epoch with missed_mask = 0.
REQ-023 In COLLECT, grant = first tap j with pending[j] and tap_valid[j], searched cyclically from start_ptr.
REQ-024 tap_ready[j] is high only when a grant exists and the output register is free (out_valid low, or out_ready high).
- tap_ready is combinational from the registered state and tap_valid; it is all zero in IDLE.
REQ-025 On transfer:
- out_data, out_tap_id and out_epoch load on the same edge; out_valid <= 1.
- pending[j] clears.
- Latency is 1 cycle from tap handshake to out_valid.
REQ-026 out_valid, out_data, out_tap_id and out_epoch hold stable while out_valid is high and out_ready is low.
- out_valid drops the cycle after an accept with no new transfer.
- Back-to-back transfers sustain 1 word per cycle.
REQ-027 timer increments each COLLECT cycle; it is not reset by transfers.
REQ-028 Epoch closes when pending becomes zero, or when timer reaches TIMEOUT-1 (whichever comes first).
- On close: epoch_done pulses; missed_mask <= pending remaining after any same-cycle transfer; state <= IDLE; start_ptr <= (start_ptr+1) mod N_TAPS.
REQ-029 A transfer in the closing cycle is delivered normally and is not counted as missed.
REQ-030 A ping edge in COLLECT sets ping_overrun and is otherwise ignored.
- A ping edge in the same cycle as close is also an overrun; the FSM does not re-enter COLLECT from it.
REQ-031 ping_overrun clears only on reset.
REQ-032 Pending output words are not discarded at epoch close; the out handshake completes independently of the FSM.

Reset
REQ-033 rst high asynchronously sets all registers to reset values:
- state IDLE; pending, timer, start_ptr, epoch and registered ping all 0.
- out_valid 0; out_data, out_tap_id and out_epoch 0.
- epoch_done 0, missed_mask 0, ping_overrun 0; tap_ready 0.
REQ-034 Reset mid-epoch abandons the epoch: no epoch_done pulse, and any held output word is dropped.
REQ-035 After rst deasserts, ping held high does not count as an edge until it has been seen low.

Verification
REQ-036 N_TAPS=4, all enabled and valid, out_ready=1, ping edge:
- words are delivered from taps 0,1,2,3 on consecutive cycles with out_epoch=1;
- epoch_done pulses the cycle after the tap 3 transfer; missed_mask=0.
REQ-037 Second epoch under the same stimulus: order is 1,2,3,0 (start_ptr rotation), out_epoch=2.
REQ-038 TIMEOUT=10, tap 2 valid never asserted:
- taps 0,1,3 are delivered;
- epoch_done occurs on COLLECT cycle 10; missed_mask=4'b0100.
REQ-039 out_ready low for 5 cycles during an epoch:
- out_data stays stable; tap_ready stays 0; no words are lost;
- after out_ready rises, delivery resumes at 1 word per cycle.
REQ-040 Ping edge 3 cycles into COLLECT: ping_overrun=1; epoch and word count are unaffected.
REQ-041 rst pulse mid-epoch while out_valid=1:
- all outputs return to 0 immediately;
- next ping edge yields out_epoch=1.
